// File: rtl/ram_window_ctrl.sv
// Loads a raster image into an external block RAM, then reads it back as
// 3x3 windows around every interior pixel, one window per handshake.
module ram_window_ctrl #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int RD_LAT = 1
) (
    input  logic        clka,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [11:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    output logic        win_valid,
    output logic [71:0] win_data,
    input  logic        win_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [11:0] LAST_PIX = 12'(IMG_W * IMG_H - 1);
    localparam logic [11:0] LAST_X   = 12'(IMG_W - 2);
    localparam logic [11:0] LAST_Y   = 12'(IMG_H - 2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        EMIT,
        FIN
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] load_cnt_q, load_cnt_d;
    logic [11:0] cx_q, cx_d;
    logic [11:0] cy_q, cy_d;
    logic [3:0]  k_q, k_d;
    logic        full_q, full_d;
    logic [71:0] win_q;

    // Read-tag pipeline: follows each issued read until its data returns.
    logic [RD_LAT-1:0] rd_vld_q;
    logic [3:0]        rd_k_q [RD_LAT];

    logic        issue;
    logic        cap8;
    logic [3:0]  ka;
    logic [1:0]  r_off, c_off;
    logic [11:0] row, col;
    logic [11:0] fetch_addr;

    assign issue = (state_q == FETCH) && (k_q <= 4'd8);
    assign cap8  = rd_vld_q[RD_LAT-1] && (rd_k_q[RD_LAT-1] == 4'd8);

    // k_q runs one past 8 while draining; the address stays on tap 8.
    always_comb begin
        ka    = (k_q > 4'd8) ? 4'd8 : k_q;
        r_off = 2'd0;
        c_off = 2'd0;
        case (ka)
            4'd0: begin r_off = 2'd0; c_off = 2'd0; end
            4'd1: begin r_off = 2'd0; c_off = 2'd1; end
            4'd2: begin r_off = 2'd0; c_off = 2'd2; end
            4'd3: begin r_off = 2'd1; c_off = 2'd0; end
            4'd4: begin r_off = 2'd1; c_off = 2'd1; end
            4'd5: begin r_off = 2'd1; c_off = 2'd2; end
            4'd6: begin r_off = 2'd2; c_off = 2'd0; end
            4'd7: begin r_off = 2'd2; c_off = 2'd1; end
            default: begin r_off = 2'd2; c_off = 2'd2; end
        endcase
        row        = cy_q + 12'(r_off) - 12'd1;
        col        = cx_q + 12'(c_off) - 12'd1;
        fetch_addr = 12'(32'(row) * 32'(IMG_W) + 32'(col));
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        k_d        = k_q;
        full_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    load_cnt_d = 12'd0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    if (load_cnt_q == LAST_PIX) begin
                        state_d    = FETCH;
                        load_cnt_d = 12'd0;
                        cx_d       = 12'd1;
                        cy_d       = 12'd1;
                        k_d        = 4'd0;
                    end else begin
                        load_cnt_d = load_cnt_q + 12'd1;
                    end
                end
            end
            FETCH: begin
                if (k_q <= 4'd8) k_d = k_q + 4'd1;
                if (full_q) begin
                    state_d = EMIT;
                end else begin
                    full_d = cap8;
                end
            end
            EMIT: begin
                if (win_ready) begin
                    if (cx_q == LAST_X && cy_q == LAST_Y) begin
                        state_d = FIN;
                    end else begin
                        state_d = FETCH;
                        k_d     = 4'd0;
                        if (cx_q == LAST_X) begin
                            cx_d = 12'd1;
                            cy_d = cy_q + 12'd1;
                        end else begin
                            cx_d = cx_q + 12'd1;
                        end
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                cx_d    = 12'd0;
                cy_d    = 12'd0;
                k_d     = 4'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            state_q    <= IDLE;
            load_cnt_q <= 12'd0;
            cx_q       <= 12'd0;
            cy_q       <= 12'd0;
            k_q        <= 4'd0;
            full_q     <= 1'b0;
            rd_vld_q   <= '0;
            win_q      <= 72'd0;
            for (int i = 0; i < RD_LAT; i++) rd_k_q[i] <= 4'd0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            k_q         <= k_d;
            full_q      <= full_d;
            rd_vld_q[0] <= issue;
            rd_k_q[0]   <= k_q;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                rd_k_q[i]   <= rd_k_q[i-1];
            end
            if (rd_vld_q[RD_LAT-1]) begin
                for (int b = 0; b < 9; b++) begin
                    if (rd_k_q[RD_LAT-1] == 4'(b)) win_q[8*b +: 8] <= ram_dout;
                end
            end
        end
    end

    // Outputs are forced quiet while reset is held, whatever the state.
    always_comb begin
        in_ready  = !reset && (state_q == LOAD);
        ram_we    = in_ready && in_valid;
        ram_din   = ram_we ? in_data : 8'd0;
        ram_addr  = 12'd0;
        if (!reset) begin
            if (state_q == LOAD) ram_addr = load_cnt_q;
            else if (state_q == FETCH || state_q == EMIT) ram_addr = fetch_addr;
        end
        win_valid = !reset && (state_q == EMIT);
        win_data  = reset ? 72'd0 : win_q;
        busy      = !reset && (state_q != IDLE);
        done      = !reset && (state_q == FIN);
    end

endmodule

// File: tb/tb_ram_window_ctrl.sv
// Bench for ram_window_ctrl: block-RAM model, image reference array and
// window model computed directly from pixel coordinates.
module tb_ram_window_ctrl;

    localparam int W = 64;
    localparam int H = 64;
    localparam int L = 1;
    localparam int N = W * H;
    localparam int NWIN = (W - 2) * (H - 2);

    logic        clka = 1'b0;
    logic        reset, start, in_valid, win_ready;
    logic [7:0]  in_data;
    logic        in_ready, ram_we, win_valid, busy, done;
    logic [11:0] ram_addr;
    logic [7:0]  ram_din, ram_dout;
    logic [71:0] win_data;

    ram_window_ctrl #(.IMG_W(W), .IMG_H(H), .RD_LAT(L)) dut (
        .clka(clka), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
        .ram_dout(ram_dout), .win_valid(win_valid), .win_data(win_data),
        .win_ready(win_ready), .busy(busy), .done(done)
    );

    always #5 clka = ~clka;

    logic [7:0] mem [N];
    logic [7:0] rd_pipe [L];
    int wr_cnt = 0;
    int done_cnt = 0;

    always @(posedge clka) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            wr_cnt <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        rd_pipe[0] <= mem[ram_addr];
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_dout = rd_pipe[L-1];

    logic [7:0] img [N];
    int n_assert = 0;
    int n_fail = 0;

    function automatic logic [71:0] exp_win(input int cx, input int cy);
        logic [71:0] w;
        w = '0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                w[8*(3*(dy+1)+(dx+1)) +: 8] = img[(cy+dy)*W + (cx+dx)];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clka);
        #1;
    endtask

    task automatic wait_win(output int lat);
        lat = 0;
        while (!win_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    function automatic int mem_mismatch();
        int mm = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== img[i]) mm++;
        return mm;
    endfunction

    initial begin
        int bad, early, lat, lat_bad, nwin, wbase, p, cx, cy;
        logic [71:0] held_d;
        logic [11:0] held_a;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0; win_ready = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", 72'(in_ready), 72'd0);
        chk("rst_ram_we", 72'(ram_we), 72'd0);
        chk("rst_ram_addr", 72'(ram_addr), 72'd0);
        chk("rst_ram_din", 72'(ram_din), 72'd0);
        chk("rst_win_valid", 72'(win_valid), 72'd0);
        chk("rst_win_data", win_data, 72'd0);
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_done", 72'(done), 72'd0);

        // reset wins over a simultaneous start
        start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        #1;
        chk("rst_prio_busy", 72'(busy), 72'd0);
        tick();
        chk("idle_busy", 72'(busy), 72'd0);

        // ---- pass 1: ramp load ----
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_busy", 72'(busy), 72'd1);
        wbase = wr_cnt;
        bad = 0;
        for (int i = 0; i < N; i++) begin
            img[i] = 8'(i);
            in_valid = 1'b1;
            in_data = 8'(i);
            start = (i == 500);
            #1;
            if (!(in_ready && ram_we && ram_addr == 12'(i) && ram_din == 8'(i))) bad++;
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
        #1;
        chk("ramp_writes", 72'(bad), 72'd0);
        chk("ramp_wr_count", 72'(wr_cnt - wbase), 72'(N));
        chk("ramp_mem", 72'(mem_mismatch()), 72'd0);
        chk("fetch_in_ready", 72'(in_ready), 72'd0);
        chk("fetch_ram_we", 72'(ram_we), 72'd0);
        chk("fetch_busy", 72'(busy), 72'd1);

        early = 0;
        for (int c = 0; c < 11; c++) begin
            if (win_valid) early++;
            tick();
        end
        chk("first_win_early", 72'(early), 72'd0);
        chk("first_win_valid", 72'(win_valid), 72'd1);
        chk("first_win_const", win_data, 72'h82_81_80_42_41_40_02_01_00);
        chk("first_win_model", win_data, exp_win(1, 1));

        // backpressure, with a stray start that must be ignored
        held_d = win_data;
        held_a = ram_addr;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            start = (c == 5);
            tick();
            start = 1'b0;
            if (!win_valid || win_data !== held_d || ram_addr !== held_a) bad++;
        end
        chk("backpressure_hold", 72'(bad), 72'd0);

        // ---- full pass at win_ready=1 ----
        win_ready = 1'b1;
        tick();
        nwin = 1;
        lat_bad = 0;
        for (int idx = 1; idx < NWIN; idx++) begin
            cx = 1 + idx % (W - 2);
            cy = 1 + idx / (W - 2);
            wait_win(lat);
            chk("win_arrive", 72'(win_valid), 72'd1);
            if (!win_valid) break;
            if (lat != 11) lat_bad++;
            if (idx == 1) chk("second_win_2_1", win_data, 72'h83_82_81_43_42_41_03_02_01);
            chk("win_data", win_data, exp_win(cx, cy));
            nwin++;
            tick();
        end
        chk("win_count", 72'(nwin), 72'(NWIN));
        chk("win_latency", 72'(lat_bad), 72'd0);
        chk("fin_done", 72'(done), 72'd1);
        chk("fin_busy", 72'(busy), 72'd1);
        tick();
        chk("post_done", 72'(done), 72'd0);
        chk("post_busy", 72'(busy), 72'd0);
        chk("done_pulses", 72'(done_cnt), 72'd1);
        repeat (15) tick();
        chk("post_win_valid", 72'(win_valid), 72'd0);

        // ---- reset mid-LOAD at byte 100 ----
        win_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data = 8'($urandom);
            tick();
        end
        in_data = 8'($urandom);
        reset = 1'b1;
        #1;
        chk("during_rst_we", 72'(ram_we), 72'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("midload_rst_busy", 72'(busy), 72'd0);
        chk("midload_rst_we", 72'(ram_we), 72'd0);
        chk("midload_rst_ready", 72'(in_ready), 72'd0);
        chk("midload_rst_addr", 72'(ram_addr), 72'd0);
        in_valid = 1'b0;
        tick();

        // ---- gapped random load ----
        start = 1'b1;
        tick();
        start = 1'b0;
        wbase = wr_cnt;
        bad = 0;
        p = 0;
        for (int c = 0; c < 2 * N; c++) begin
            in_valid = (c % 2 == 0);
            in_data = 8'($urandom);
            #1;
            if (in_valid) begin
                img[p] = in_data;
                if (!(ram_we && ram_addr == 12'(p) && ram_din == in_data)) bad++;
                p++;
            end else if (ram_we) begin
                bad++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("gap_writes", 72'(bad), 72'd0);
        chk("gap_wr_count", 72'(wr_cnt - wbase), 72'(N));
        chk("gap_mem", 72'(mem_mismatch()), 72'd0);

        win_ready = 1'b1;
        for (int idx = 0; idx < 5; idx++) begin
            wait_win(lat);
            chk("rnd_win_arrive", 72'(win_valid), 72'd1);
            if (!win_valid) break;
            chk("rnd_win_data", win_data, exp_win(1 + idx, 1));
            tick();
        end

        // ---- reset mid-EMIT ----
        win_ready = 1'b0;
        wait_win(lat);
        chk("emit_arrive", 72'(win_valid), 72'd1);
        chk("emit_data", win_data, exp_win(6, 1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("midemit_win_valid", 72'(win_valid), 72'd0);
        chk("midemit_win_data", win_data, 72'd0);
        chk("midemit_busy", 72'(busy), 72'd0);
        chk("midemit_addr", 72'(ram_addr), 72'd0);
        chk("midemit_done", 72'(done), 72'd0);
        repeat (5) tick();
        chk("final_idle", 72'(busy), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_window_ctrl.md
RAM_WINDOW_CTRL -- requirements
Module: ram_window_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_W, default 64, meaning image width in pixels.
REQ-002 The block SHALL have parameter IMG_H, default 64, meaning image height in pixels; IMG_W*IMG_H <= 4096.
REQ-003 The block SHALL have parameter RD_LAT, default 1, meaning block-RAM read latency in cycles (1..2).
REQ-004 The block SHALL have port clka, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle request to begin a load and filter pass.
REQ-007 The block SHALL have port in_valid, input, 1 bit: pixel byte available on in_data.
REQ-008 The block SHALL have port in_data, input, 8 bits: raster-order pixel stream.
REQ-009 The block SHALL have port in_ready, output, 1 bit: asserted when the block accepts a pixel.
REQ-010 The block SHALL have port ram_addr, output, 12 bits: block-RAM address.
REQ-011 The block SHALL have port ram_we, output, 1 bit: block-RAM write enable.
REQ-012 The block SHALL have port ram_din, output, 8 bits: block-RAM write data.
REQ-013 The block SHALL have port ram_dout, input, 8 bits: block-RAM read data.
REQ-014 The block SHALL have port win_valid, output, 1 bit: 3x3 window valid.
REQ-015 The block SHALL have port win_data, output, 72 bits: window; byte k at [8k+7:8k], k=3*(dy+1)+(dx+1), dy,dx in {-1,0,1}.
REQ-016 The block SHALL have port win_ready, input, 1 bit: consumer accepts the window.
REQ-017 The block SHALL have ports busy and done, outputs, 1 bit each: pass in progress, and one-cycle pass-complete pulse.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, FETCH, EMIT, FIN.
REQ-019 In IDLE, start=1 SHALL move the FSM to LOAD with the load counter at 0; start SHALL be ignored in any other state.
REQ-020 In LOAD, in_ready=1; on in_valid=1: ram_we=1, ram_addr=load counter, ram_din=in_data (all combinational), and the counter increments.
REQ-021 After accepting byte IMG_W*IMG_H-1, the FSM SHALL enter FETCH with center (cx,cy)=(1,1) and issue index k=0.
REQ-022 In FETCH, ram_we=0 and ram_addr=(cy+dy)*IMG_W+(cx+dx) for issue index k, truncated to 12 bits; k increments each cycle 0..8, and the address is held at k=8 while draining.
REQ-023 Read data for issue k SHALL be captured from ram_dout RD_LAT cycles after issue, into win_data byte k.
REQ-024 In the cycle after byte 8 is captured, the FSM SHALL enter EMIT with win_valid=1; win_data SHALL remain stable while win_valid=1 and win_ready=0.
REQ-025 On win_valid&win_ready, cx SHALL advance; past IMG_W-2 it SHALL wrap to 1 and cy increments; the FSM returns to FETCH with k=0, or goes to FIN after center (IMG_W-2,IMG_H-2).
REQ-026 Only interior centers SHALL be emitted: (IMG_W-2)*(IMG_H-2) windows, 3844 at the default parameters.
REQ-027 FIN SHALL last one cycle with done=1 and then return to IDLE.
REQ-028 busy SHALL be 1 in LOAD, FETCH, EMIT and FIN, and 0 in IDLE.
REQ-029 in_ready SHALL be 0 outside LOAD; ram_we SHALL be 0 outside LOAD.
REQ-030 Each window SHALL take 9 + RD_LAT + 1 cycles minimum from FETCH entry to win_valid.

Reset
REQ-031 On reset=1 at a clock edge, the FSM SHALL go to IDLE and all counters and win_data SHALL be cleared to 0, in any state, including mid-LOAD and mid-EMIT.
REQ-032 During and after reset, in_ready=0, ram_we=0, ram_addr=0, ram_din=0, win_valid=0, busy=0 and done=0 until start.
REQ-033 reset SHALL have priority over start in the same cycle.

Verification
REQ-034 Load ramp: start, then 4096 bytes with value addr[7:0] and continuous in_valid -> 4096 writes at addresses 0..4095, then FETCH, in_ready=0.
REQ-035 First window, RD_LAT=1: after the ramp -> win_data bytes = {0x82,0x81,0x80,0x42,0x41,0x40,0x02,0x01,0x00} (byte8..byte0), win_valid 11 cycles after FETCH entry.
REQ-036 Backpressure: win_ready=0 for 20 cycles -> win_valid and win_data held, no address change, then advance to (2,1).
REQ-037 Full pass, win_ready=1 -> exactly 3844 windows, center order row-major, last center (62,62), done pulse once, then IDLE, busy=0.
REQ-038 Reset mid-LOAD at byte 100 -> next cycle IDLE, ram_we=0; a new start reloads from address 0.
REQ-039 Gapped input, in_valid toggled every other cycle -> writes only on in_valid=1 cycles, addresses contiguous.
